// File: rtl/ocx_tlx_bdi_tracker.sv
// Multi-channel BDI tracker: pairs bookend BDI bits with arbiter channel tags and
// stores one bit per flit per channel. Optional macro OCX_TLX_BDI_OVF_CHK_EN enables err.
module ocx_tlx_bdi_tracker #(
  parameter int NUM_CH  = 3,
  parameter int CH_W    = 2,
  parameter int ADDR_W  = 8,
  parameter int BDI_W   = 8,
  parameter int Q_DEPTH = 16
) (
  input  logic                         tlx_clk,
  input  logic                         reset_n,
  input  logic                         bdi_v,
  input  logic [BDI_W-1:0]             bdi_vec,
  input  logic [3:0]                   bdi_cnt,
  input  logic                         tag_v,
  input  logic [CH_W-1:0]              tag_ch,
  input  logic [1:0]                   tag_flits,
  input  logic [NUM_CH-1:0]            rd_ena,
  input  logic [NUM_CH*ADDR_W-1:0]     rd_ptr,
  output logic [NUM_CH-1:0]            bdi_out,
  output logic [NUM_CH*ADDR_W-1:0]     wr_cnt,
  output logic [$clog2(Q_DEPTH):0]     bit_occ,
  output logic [$clog2(Q_DEPTH):0]     tag_occ,
  output logic                         err
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [OCC_W-1:0] Q_FULL = OCC_W'(Q_DEPTH);

  logic [Q_DEPTH-1:0] bit_q;
  logic [CH_W-1:0]    tag_q [Q_DEPTH];
  logic [PTR_W-1:0]   bit_wp, bit_rp, tag_wp, tag_rp;
  logic [ADDR_W-1:0]  wp_q [NUM_CH];
  logic               mem [NUM_CH][DEPTH];

  logic [OCC_W-1:0]   bit_req, bit_room, bit_acc;
  logic [OCC_W-1:0]   tag_req, tag_room, tag_acc;
  logic               bit_ovf, tag_ovf, tag_bad, pop;
  logic [CH_W-1:0]    pop_ch;
  logic               pop_bit;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    bit_req = '0;
    if (bdi_v)
      bit_req = (int'(bdi_cnt) > BDI_W) ? OCC_W'(BDI_W) : OCC_W'(bdi_cnt);
    bit_room = Q_FULL - bit_occ;
    bit_ovf  = bit_req > bit_room;
    bit_acc  = bit_ovf ? bit_room : bit_req;

    tag_bad = tag_v && (int'(tag_ch) >= NUM_CH);
    tag_req = '0;
    if (tag_v && !tag_bad) begin
      case (tag_flits)
        2'b01:   tag_req = OCC_W'(1);
        2'b10:   tag_req = OCC_W'(2);
        2'b11:   tag_req = OCC_W'(4);
        default: tag_req = '0;
      endcase
    end
    tag_room = Q_FULL - tag_occ;
    tag_ovf  = tag_req > tag_room;
    tag_acc  = tag_ovf ? tag_room : tag_req;

    // Pairing looks only at registered occupancy, so a push is seen one cycle later.
    pop     = (bit_occ != '0) && (tag_occ != '0);
    pop_ch  = tag_q[tag_rp];
    pop_bit = bit_q[bit_rp];
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      bit_wp  <= '0;
      bit_rp  <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      bit_occ <= '0;
      tag_occ <= '0;
      for (int c = 0; c < NUM_CH; c++) wp_q[c] <= '0;
    end else begin
      bit_wp  <= bit_wp + PTR_W'(bit_acc);
      bit_rp  <= bit_rp + PTR_W'(pop);
      bit_occ <= bit_occ + bit_acc - OCC_W'(pop);
      tag_wp  <= tag_wp + PTR_W'(tag_acc);
      tag_rp  <= tag_rp + PTR_W'(pop);
      tag_occ <= tag_occ + tag_acc - OCC_W'(pop);
      if (pop) wp_q[pop_ch] <= wp_q[pop_ch] + ADDR_W'(1);
    end
  end

  // NOTE: queue storage and BDI arrays are never reset; pointers and occupancy give them meaning.
  always_ff @(posedge tlx_clk) begin
    for (int i = 0; i < BDI_W; i++)
      if (OCC_W'(i) < bit_acc) bit_q[bit_wp + PTR_W'(i)] <= bdi_vec[i];
    for (int i = 0; i < 4; i++)
      if (OCC_W'(i) < tag_acc) tag_q[tag_wp + PTR_W'(i)] <= tag_ch;
    if (reset_n && pop) mem[pop_ch][wp_q[pop_ch]] <= pop_bit;
  end

  // Reads sample the array before this edge's write, so a collision returns old data.
  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      bdi_out <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        bdi_out[c] <= rd_ena[c] ? mem[c][rd_ptr[c*ADDR_W +: ADDR_W]] : 1'b0;
    end
  end

  always_comb begin
    wr_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) wr_cnt[c*ADDR_W +: ADDR_W] = wp_q[c];
  end

`ifdef OCX_TLX_BDI_OVF_CHK_EN
  always_ff @(posedge tlx_clk) begin
    if (!reset_n)                            err <= 1'b0;
    else if (bit_ovf || tag_ovf || tag_bad)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ocx_tlx_bdi_tracker.sv
// Self-checking bench for ocx_tlx_bdi_tracker: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ocx_tlx_bdi_tracker;

  localparam int NUM_CH  = 3;
  localparam int CH_W    = 2;
  localparam int ADDR_W  = 3;
  localparam int BDI_W   = 8;
  localparam int Q_DEPTH = 16;
  localparam int DEPTH   = 1 << ADDR_W;
`ifdef OCX_TLX_BDI_OVF_CHK_EN
  localparam bit OVF_CHK = 1'b1;
`else
  localparam bit OVF_CHK = 1'b0;
`endif

  logic                     tlx_clk, reset_n;
  logic                     bdi_v, tag_v;
  logic [BDI_W-1:0]         bdi_vec;
  logic [3:0]               bdi_cnt;
  logic [CH_W-1:0]          tag_ch;
  logic [1:0]               tag_flits;
  logic [NUM_CH-1:0]        rd_ena;
  logic [NUM_CH*ADDR_W-1:0] rd_ptr;
  logic [NUM_CH-1:0]        bdi_out;
  logic [NUM_CH*ADDR_W-1:0] wr_cnt;
  logic [$clog2(Q_DEPTH):0] bit_occ, tag_occ;
  logic                     err;

  ocx_tlx_bdi_tracker #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .BDI_W(BDI_W), .Q_DEPTH(Q_DEPTH)
  ) dut (
    .tlx_clk(tlx_clk), .reset_n(reset_n),
    .bdi_v(bdi_v), .bdi_vec(bdi_vec), .bdi_cnt(bdi_cnt),
    .tag_v(tag_v), .tag_ch(tag_ch), .tag_flits(tag_flits),
    .rd_ena(rd_ena), .rd_ptr(rd_ptr),
    .bdi_out(bdi_out), .wr_cnt(wr_cnt), .bit_occ(bit_occ), .tag_occ(tag_occ), .err(err)
  );

  initial tlx_clk = 1'b0;
  always #5 tlx_clk = ~tlx_clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs of bits and channel tags, per-channel arrays and write counts.
  bit   mq_b[$];
  int   mq_t[$];
  logic mmem [NUM_CH][DEPTH];
  int   mwc [NUM_CH];
  logic [NUM_CH-1:0] mout;
  bit   merr;

  always @(posedge tlx_clk) begin : model
    int cap_b, cap_t, n, ch;
    bit b, bad;
    if (!reset_n) begin
      mq_b.delete();
      mq_t.delete();
      for (int c = 0; c < NUM_CH; c++) mwc[c] = 0;
      mout = '0;
      merr = 1'b0;
    end else begin
      cap_b = Q_DEPTH - mq_b.size();
      cap_t = Q_DEPTH - mq_t.size();
      for (int c = 0; c < NUM_CH; c++)
        mout[c] = rd_ena[c] ? mmem[c][rd_ptr[c*ADDR_W +: ADDR_W]] : 1'b0;
      if (mq_b.size() > 0 && mq_t.size() > 0) begin
        b  = mq_b.pop_front();
        ch = mq_t.pop_front();
        mmem[ch][mwc[ch]] = b;
        mwc[ch] = (mwc[ch] + 1) % DEPTH;
      end
      bad = 1'b0;
      if (bdi_v) begin
        n = (bdi_cnt > BDI_W) ? BDI_W : int'(bdi_cnt);
        for (int i = 0; i < n; i++)
          if (i < cap_b) mq_b.push_back(bdi_vec[i]); else bad = 1'b1;
      end
      if (tag_v) begin
        if (int'(tag_ch) >= NUM_CH) bad = 1'b1;
        else begin
          n = (tag_flits == 2'd0) ? 0 : (1 << (tag_flits - 1));
          for (int i = 0; i < n; i++)
            if (i < cap_t) mq_t.push_back(int'(tag_ch)); else bad = 1'b1;
        end
      end
      if (bad && OVF_CHK) merr = 1'b1;
    end
  end

  always @(negedge tlx_clk) begin
    if (chk_on) begin
      check("bit_occ", bit_occ, mq_b.size());
      check("tag_occ", tag_occ, mq_t.size());
      for (int c = 0; c < NUM_CH; c++)
        check("wr_cnt", wr_cnt[c*ADDR_W +: ADDR_W], mwc[c]);
      check("bdi_out", bdi_out, mout);
      check("err", err, merr);
    end
  end

  task automatic tick();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic clear_in();
    bdi_v = 0; bdi_vec = '0; bdi_cnt = '0;
    tag_v = 0; tag_ch = '0; tag_flits = '0;
    rd_ena = '0; rd_ptr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int ptr, input logic exp, input string name);
    rd_ena = '0;
    rd_ena[ch] = 1'b1;
    rd_ptr = '0;
    rd_ptr[ch*ADDR_W +: ADDR_W] = ADDR_W'(ptr);
    tick();
    rd_ena = '0;
    check(name, bdi_out[ch], exp);
  endtask

  initial begin
    clear_in();
    reset_n = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    reset_n = 1'b1;
    check("rst_bit_occ", bit_occ, 0);
    check("rst_tag_occ", tag_occ, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_bdi_out", bdi_out, 0);
    check("rst_err", err, 0);

    // Single 4-flit transfer on ch1 with bits 1,0,1,0
    do_reset();
    tag_v = 1; tag_ch = 2'd1; tag_flits = 2'b11;
    bdi_v = 1; bdi_cnt = 4'd4; bdi_vec = 8'b0000_0101;
    tick(); clear_in();
    check("s1_bit_occ", bit_occ, 4);
    check("s1_tag_occ", tag_occ, 4);
    repeat (4) tick();
    check("s1_wr_cnt1", wr_cnt[1*ADDR_W +: ADDR_W], 4);
    rd(1, 2, 1'b1, "s1_rd2");
    rd(1, 0, 1'b1, "s1_rd0");
    rd(1, 1, 1'b0, "s1_rd1");
    rd(1, 3, 1'b0, "s1_rd3");

    // Tags lead bits by five cycles
    do_reset();
    tag_v = 1; tag_ch = 2'd0; tag_flits = 2'b10;
    tick(); clear_in();
    repeat (4) tick();
    check("s2_tag_wait", tag_occ, 2);
    check("s2_no_write", wr_cnt[0 +: ADDR_W], 0);
    bdi_v = 1; bdi_cnt = 4'd2; bdi_vec = 8'b10;
    tick(); clear_in();
    check("s2_tag_hold", tag_occ, 2);
    check("s2_bit_occ", bit_occ, 2);
    tick();
    check("s2_tag_pop", tag_occ, 1);
    tick();
    check("s2_wr_cnt0", wr_cnt[0 +: ADDR_W], 2);
    rd(0, 0, 1'b0, "s2_rd0");
    rd(0, 1, 1'b1, "s2_rd1");

    // Interleaved channels: ch2(1), ch0(2), ch2(1) with bits 1,1,0,1
    do_reset();
    bdi_v = 1; bdi_cnt = 4'd4; bdi_vec = 8'b1011;
    tag_v = 1; tag_ch = 2'd2; tag_flits = 2'b01;
    tick();
    bdi_v = 0; tag_ch = 2'd0; tag_flits = 2'b10;
    tick();
    tag_ch = 2'd2; tag_flits = 2'b01;
    tick(); clear_in();
    repeat (5) tick();
    check("s3_wr_cnt", wr_cnt, 9'b010_000_010);
    rd(2, 0, 1'b1, "s3_rd20");
    rd(0, 0, 1'b1, "s3_rd00");
    rd(0, 1, 1'b0, "s3_rd01");
    rd(2, 1, 1'b1, "s3_rd21");

    // Wrap: ten single-flit ch0 transfers into an 8-deep array
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tag_v = 1; tag_ch = 2'd0; tag_flits = 2'b01;
      bdi_v = 0;
      if (i == 0) begin bdi_v = 1; bdi_cnt = 4'd8; bdi_vec = 8'h01; end
      if (i == 1) begin bdi_v = 1; bdi_cnt = 4'd2; bdi_vec = 8'b10; end
      tick();
    end
    clear_in();
    repeat (3) tick();
    check("s4_wr_cnt0", wr_cnt[0 +: ADDR_W], 2);
    rd(0, 0, 1'b0, "s4_rd0_overwritten");
    rd(0, 1, 1'b1, "s4_rd1");

    // Bit-queue overflow: three 8-bit runs, no tags
    do_reset();
    bdi_v = 1; bdi_cnt = 4'd8; bdi_vec = 8'hFF;
    tick(); tick();
    check("s5_occ_full", bit_occ, 16);
    check("s5_err_pre", err, 0);
    tick(); clear_in();
    check("s5_occ_sat", bit_occ, 16);
    check("s5_err", err, OVF_CHK);

    // Count clamp and illegal channel
    do_reset();
    bdi_v = 1; bdi_cnt = 4'd15; bdi_vec = 8'hA5;
    tick(); clear_in();
    check("s5_clamp", bit_occ, 8);
    tag_v = 1; tag_ch = 2'd3; tag_flits = 2'b01;
    tick(); clear_in();
    check("s5_bad_tag_occ", tag_occ, 0);
    check("s5_bad_tag_err", err, OVF_CHK);

    // Reset mid-run with a pairing pending on the reset edge
    do_reset();
    bdi_v = 1; bdi_cnt = 4'd5; bdi_vec = 8'h00;
    tick(); clear_in();
    check("s6_bit_occ", bit_occ, 5);
    tag_v = 1; tag_ch = 2'd1; tag_flits = 2'b01;
    tick(); clear_in();
    check("s6_tag_occ", tag_occ, 1);
    reset_n = 1'b0;
    rd_ena = 3'b010; rd_ptr = '0;
    tick();
    reset_n = 1'b1; rd_ena = '0;
    check("s6_bit_occ0", bit_occ, 0);
    check("s6_tag_occ0", tag_occ, 0);
    check("s6_wr_cnt0", wr_cnt, 0);
    check("s6_bdi_out0", bdi_out, 0);
    check("s6_err0", err, 0);
    rd(1, 0, 1'b1, "s6_no_write");

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
